// File: rtl/match_sequencer.sv
`timescale 1ns/1ps
// Round-robin buy/sell arbiter feeding a best-bid/best-ask book, sequencing the compare, match and cooldown phases.
// Optional build macro MSEQ_SENTINEL_REJECT_EN: sentinel-priced orders are acked but never reach the book.
module match_sequencer #(
    parameter int PRICE_W     = 8,
    parameter int CNT_W       = 16,
    parameter int HOLD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               buy_req,
    input  logic [PRICE_W-1:0] buy_price,
    input  logic               sell_req,
    input  logic [PRICE_W-1:0] sell_price,
    output logic               buy_ack,
    output logic               sell_ack,
    output logic [PRICE_W-1:0] best_bid,
    output logic [PRICE_W-1:0] best_ask,
    output logic               match_signal,
    output logic [PRICE_W-1:0] match_price,
    output logic               enable_count,
    output logic [CNT_W-1:0]   match_count,
`ifdef MSEQ_SENTINEL_REJECT_EN
    output logic               reject_pulse,
`endif
    output logic               busy
);

    typedef enum logic [2:0] {IDLE, GRANT, CHECK, MATCH, HOLD} state_t;

    localparam logic [PRICE_W-1:0] BID_EMPTY = '0;
    localparam logic [PRICE_W-1:0] ASK_EMPTY = '1;
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [7:0]         HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t             state_q, state_d;
    logic               grant_buy_q, grant_buy_d;
    logic               last_buy_q, last_buy_d;
    logic [PRICE_W-1:0] price_q, price_d;
    logic [PRICE_W-1:0] bid_q, bid_d;
    logic [PRICE_W-1:0] ask_q, ask_d;
    logic [PRICE_W-1:0] mprice_q, mprice_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               buy_ack_q, buy_ack_d;
    logic               sell_ack_q, sell_ack_d;
    logic               match_q, match_d;
    logic [7:0]         hold_q, hold_d;
    logic               take_buy;
    logic               crossed;
`ifdef MSEQ_SENTINEL_REJECT_EN
    logic               rej_q, rej_d;
`endif

    always_comb begin
        state_d     = state_q;
        grant_buy_d = grant_buy_q;
        last_buy_d  = last_buy_q;
        price_d     = price_q;
        bid_d       = bid_q;
        ask_d       = ask_q;
        mprice_d    = mprice_q;
        count_d     = count_q;
        hold_d      = hold_q;
        buy_ack_d   = 1'b0;
        sell_ack_d  = 1'b0;
        match_d     = 1'b0;
`ifdef MSEQ_SENTINEL_REJECT_EN
        rej_d       = 1'b0;
`endif
        // On a simultaneous request the side that did not win last time goes first.
        take_buy = buy_req && (!sell_req || !last_buy_q);
        crossed  = (bid_q != BID_EMPTY) && (ask_q != ASK_EMPTY) && (bid_q >= ask_q);

        case (state_q)
            IDLE: begin
                if (buy_req || sell_req) begin
                    grant_buy_d = take_buy;
                    last_buy_d  = take_buy;
                    price_d     = take_buy ? buy_price : sell_price;
                    buy_ack_d   = take_buy;
                    sell_ack_d  = !take_buy;
                    state_d     = GRANT;
`ifdef MSEQ_SENTINEL_REJECT_EN
                    rej_d       = take_buy ? (buy_price == BID_EMPTY) : (sell_price == ASK_EMPTY);
`endif
                end
            end
            GRANT: begin
                state_d = CHECK;
                if (grant_buy_q) begin
                    if (price_q > bid_q) bid_d = price_q;
                end else if (price_q < ask_q) begin
                    ask_d = price_q;
                end
`ifdef MSEQ_SENTINEL_REJECT_EN
                if (rej_q) begin
                    state_d = IDLE;
                    bid_d   = bid_q;
                    ask_d   = ask_q;
                end
`endif
            end
            CHECK: begin
                if (crossed) begin
                    state_d  = MATCH;
                    match_d  = 1'b1;
                    mprice_d = ask_q;
                    if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            MATCH: begin
                bid_d   = BID_EMPTY;
                ask_d   = ASK_EMPTY;
                hold_d  = HOLD_LOAD;
                state_d = HOLD;
            end
            HOLD: begin
                if (hold_q == 8'd0) state_d = IDLE;
                else                hold_d  = hold_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_buy_q <= 1'b0;
            last_buy_q  <= 1'b0;
            price_q     <= '0;
            bid_q       <= BID_EMPTY;
            ask_q       <= ASK_EMPTY;
            mprice_q    <= '0;
            count_q     <= '0;
            hold_q      <= '0;
            buy_ack_q   <= 1'b0;
            sell_ack_q  <= 1'b0;
            match_q     <= 1'b0;
`ifdef MSEQ_SENTINEL_REJECT_EN
            rej_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_buy_q <= grant_buy_d;
            last_buy_q  <= last_buy_d;
            price_q     <= price_d;
            bid_q       <= bid_d;
            ask_q       <= ask_d;
            mprice_q    <= mprice_d;
            count_q     <= count_d;
            hold_q      <= hold_d;
            buy_ack_q   <= buy_ack_d;
            sell_ack_q  <= sell_ack_d;
            match_q     <= match_d;
`ifdef MSEQ_SENTINEL_REJECT_EN
            rej_q       <= rej_d;
`endif
        end
    end

    assign buy_ack      = buy_ack_q;
    assign sell_ack     = sell_ack_q;
    assign best_bid     = bid_q;
    assign best_ask     = ask_q;
    assign match_signal = match_q;
    assign match_price  = mprice_q;
    assign match_count  = count_q;
    assign enable_count = (bid_q != BID_EMPTY) && (ask_q != ASK_EMPTY);
    assign busy         = (state_q != IDLE);
`ifdef MSEQ_SENTINEL_REJECT_EN
    assign reject_pulse = rej_q;
`endif

endmodule

// File: tb/tb_match_sequencer.sv
`timescale 1ns/1ps
// Bench for match_sequencer: a transaction-timeline model predicts every output per cycle; a second
// instance with a 2-bit counter exercises saturation. Honours MSEQ_SENTINEL_REJECT_EN when defined.
module tb_match_sequencer;

    localparam int H = 2;
    localparam int N = 8192;
`ifdef MSEQ_SENTINEL_REJECT_EN
    localparam bit REJ_EN = 1'b1;
`else
    localparam bit REJ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       buy_req = 1'b0, sell_req = 1'b0;
    logic [7:0] buy_price = 8'h00, sell_price = 8'h00;

    logic        buy_ack, sell_ack, match_signal, enable_count, busy;
    logic [7:0]  best_bid, best_ask, match_price;
    logic [15:0] match_count;
    logic        b_buy_ack, b_sell_ack, b_match_signal, b_enable_count, b_busy;
    logic [7:0]  b_best_bid, b_best_ask, b_match_price;
    logic [1:0]  b_match_count;
`ifdef MSEQ_SENTINEL_REJECT_EN
    logic        reject_pulse, b_reject_pulse;
`endif

    match_sequencer #(.PRICE_W(8), .CNT_W(16), .HOLD_CYCLES(H)) dut (
        .clk(clk), .reset(reset),
        .buy_req(buy_req), .buy_price(buy_price), .sell_req(sell_req), .sell_price(sell_price),
        .buy_ack(buy_ack), .sell_ack(sell_ack), .best_bid(best_bid), .best_ask(best_ask),
        .match_signal(match_signal), .match_price(match_price), .enable_count(enable_count),
        .match_count(match_count),
`ifdef MSEQ_SENTINEL_REJECT_EN
        .reject_pulse(reject_pulse),
`endif
        .busy(busy)
    );

    match_sequencer #(.PRICE_W(8), .CNT_W(2), .HOLD_CYCLES(H)) dut_sat (
        .clk(clk), .reset(reset),
        .buy_req(buy_req), .buy_price(buy_price), .sell_req(sell_req), .sell_price(sell_price),
        .buy_ack(b_buy_ack), .sell_ack(b_sell_ack), .best_bid(b_best_bid), .best_ask(b_best_ask),
        .match_signal(b_match_signal), .match_price(b_match_price), .enable_count(b_enable_count),
        .match_count(b_match_count),
`ifdef MSEQ_SENTINEL_REJECT_EN
        .reject_pulse(b_reject_pulse),
`endif
        .busy(b_busy)
    );

    always #5 clk = ~clk;

    // Expected outputs per cycle index
    bit         e_ab[N], e_as[N], e_m[N], e_busy[N], e_rej[N];
    logic [7:0] e_bid[N], e_ask[N], e_mp[N];
    int         e_cnt[N];

    int         cyc = 0, free_at = 0, m_cnt = 0;
    logic [7:0] m_bid = 8'h00, m_ask = 8'hFF, m_mp = 8'h00;
    bit         last_buy = 1'b0;
    int         vectors = 0, miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic put(input int i, input bit ab, input bit as, input bit m, input bit b, input bit rj);
        e_ab[i] = ab; e_as[i] = as; e_m[i] = m; e_busy[i] = b; e_rej[i] = rj;
        e_bid[i] = m_bid; e_ask[i] = m_ask; e_mp[i] = m_mp; e_cnt[i] = m_cnt;
    endtask

    // Transaction-level prediction: once a request is accepted, lay out its whole timeline ahead.
    task automatic model_step();
        int n;
        bit gb, sentinel;
        logic [7:0] p;
        n = cyc;
        if (n < free_at) return;
        put(n + 1, 0, 0, 0, 0, 0);
        if (reset || !(buy_req || sell_req)) return;
        if (buy_req && sell_req) gb = !last_buy;
        else                     gb = buy_req;
        last_buy = gb;
        p = gb ? buy_price : sell_price;
        sentinel = gb ? (p == 8'h00) : (p == 8'hFF);
        put(n + 1, gb, !gb, 0, 1, REJ_EN && sentinel);
        if (REJ_EN && sentinel) begin
            free_at = n + 2;
            put(free_at, 0, 0, 0, 0, 0);
            return;
        end
        if (gb) m_bid = (p > m_bid) ? p : m_bid;
        else    m_ask = (p < m_ask) ? p : m_ask;
        put(n + 2, 0, 0, 0, 1, 0);
        if (m_bid != 8'h00 && m_ask != 8'hFF && m_bid >= m_ask) begin
            m_mp = m_ask;
            m_cnt++;
            put(n + 3, 0, 0, 1, 1, 0);
            m_bid = 8'h00;
            m_ask = 8'hFF;
            for (int k = 1; k <= H; k++) put(n + 3 + k, 0, 0, 0, 1, 0);
            free_at = n + 4 + H;
        end else begin
            free_at = n + 3;
        end
        put(free_at, 0, 0, 0, 0, 0);
    endtask

    task automatic compare_all();
        int sat;
        sat = (e_cnt[cyc] > 3) ? 3 : e_cnt[cyc];
        chk("buy_ack", buy_ack, e_ab[cyc]);
        chk("sell_ack", sell_ack, e_as[cyc]);
        chk("best_bid", best_bid, e_bid[cyc]);
        chk("best_ask", best_ask, e_ask[cyc]);
        chk("match_signal", match_signal, e_m[cyc]);
        chk("match_price", match_price, e_mp[cyc]);
        chk("enable_count", enable_count, (e_bid[cyc] != 8'h00) && (e_ask[cyc] != 8'hFF));
        chk("match_count", match_count, e_cnt[cyc]);
        chk("busy", busy, e_busy[cyc]);
`ifdef MSEQ_SENTINEL_REJECT_EN
        chk("reject_pulse", reject_pulse, e_rej[cyc]);
`endif
        chk("sat_outputs",
            {b_buy_ack, b_sell_ack, b_match_signal, b_enable_count, b_busy, b_best_bid, b_best_ask,
             b_match_price, b_match_count},
            {e_ab[cyc], e_as[cyc], e_m[cyc], (e_bid[cyc] != 8'h00) && (e_ask[cyc] != 8'hFF),
             e_busy[cyc], e_bid[cyc], e_ask[cyc], e_mp[cyc], 2'(sat)});
    endtask

    // One clock cycle: compare after the edge, drive requesters, then predict at the falling edge.
    task automatic tick(input bit rb, input logic [7:0] pb, input bit rs, input logic [7:0] ps);
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            m_bid = 8'h00; m_ask = 8'hFF; m_mp = 8'h00; m_cnt = 0; last_buy = 1'b0;
            free_at = cyc;
            put(cyc, 0, 0, 0, 0, 0);
        end
        compare_all();
        #2;
        reset = 1'b0;
        if (buy_req && e_ab[cyc]) buy_req = 1'b0;
        else if (rb && !buy_req) begin buy_req = 1'b1; buy_price = pb; end
        if (sell_req && e_as[cyc]) sell_req = 1'b0;
        else if (rs && !sell_req) begin sell_req = 1'b1; sell_price = ps; end
        @(negedge clk);
        model_step();
    endtask

    task automatic tick0();
        tick(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic txn(input bit is_buy, input logic [7:0] p);
        tick(is_buy, p, !is_buy, p);
        for (int k = 0; k < 3; k++) tick0();
    endtask

    // Asynchronous reset mid-cycle; released by the next tick after one clock edge.
    task automatic do_reset();
        reset = 1'b1;
        buy_req = 1'b0;
        sell_req = 1'b0;
        #1;
        chk("rst_bid", best_bid, 8'h00);
        chk("rst_ask", best_ask, 8'hFF);
        chk("rst_acks", {buy_ack, sell_ack}, 2'b00);
        chk("rst_match", match_signal, 1'b0);
        chk("rst_mprice", match_price, 8'h00);
        chk("rst_count", match_count, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_enable", enable_count, 1'b0);
        chk("rst_sat_count", b_match_count, 2'b00);
    endtask

    function automatic logic [7:0] rand_price();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'hFF;
        return 8'($urandom_range(8'h30, 8'h70));
    endfunction

    initial begin
        #1;
        do_reset();
        tick0();

        // Lone buy at 0x40
        tick(1'b1, 8'h40, 1'b0, 8'h00);
        tick0(); chk("s1_buy_ack", buy_ack, 1'b1); chk("s1_busy", busy, 1'b1);
        tick0(); chk("s1_bid", best_bid, 8'h40);
        tick0(); chk("s1_idle", busy, 1'b0); chk("s1_ask", best_ask, 8'hFF);
        chk("s1_enable", enable_count, 1'b0); chk("s1_nomatch", match_signal, 1'b0);

        // Sell 0x3C crosses the resting 0x40 bid
        tick(1'b0, 8'h00, 1'b1, 8'h3C);
        tick0(); chk("s2_sell_ack", sell_ack, 1'b1);
        tick0(); chk("s2_enable", enable_count, 1'b1);
        tick0(); chk("s2_match", match_signal, 1'b1); chk("s2_mprice", match_price, 8'h3C);
        chk("s2_count", match_count, 16'd1);
        tick0(); chk("s2_cleared", {best_bid, best_ask}, 16'h00FF); chk("s2_hold1", busy, 1'b1);
        chk("s2_enable_fall", enable_count, 1'b0);
        tick0(); chk("s2_hold2", busy, 1'b1);
        tick0(); chk("s2_idle", busy, 1'b0);

        // Simultaneous requests: buy first, sell on the next IDLE
        do_reset();
        tick0();
        tick(1'b1, 8'h10, 1'b1, 8'h20);
        tick0(); chk("s3_buy_first", {buy_ack, sell_ack}, 2'b10);
        tick0(); tick0();
        tick0(); chk("s3_sell_next", {buy_ack, sell_ack}, 2'b01);
        tick0(); tick0();
        chk("s3_book", {best_bid, best_ask}, 16'h1020); chk("s3_enable", enable_count, 1'b1);
        chk("s3_nomatch", match_count, 16'd0); chk("s3_idle", busy, 1'b0);

        // Worse prices leave the book alone; equality crosses
        do_reset();
        tick0();
        txn(1'b0, 8'h50); txn(1'b0, 8'h60); chk("s4_ask_kept", best_ask, 8'h50);
        txn(1'b1, 8'h30); txn(1'b1, 8'h20); chk("s4_bid_kept", best_bid, 8'h30);
        tick(1'b1, 8'h50, 1'b0, 8'h00);
        tick0(); tick0();
        tick0(); chk("s5_eq_match", match_signal, 1'b1); chk("s5_eq_price", match_price, 8'h50);
        tick0(); chk("s5_in_hold", busy, 1'b1);
        do_reset();                                   // reset during HOLD
        tick0();
        tick(1'b1, 8'h77, 1'b0, 8'h00);
        tick0(); chk("s6_grant", buy_ack, 1'b1);
        do_reset();                                   // reset during GRANT drops the ack
        tick0();

        // Sentinel-priced sell
        tick(1'b0, 8'h00, 1'b1, 8'hFF);
        tick0(); chk("s7_sell_ack", sell_ack, 1'b1);
`ifdef MSEQ_SENTINEL_REJECT_EN
        chk("s7_reject", reject_pulse, 1'b1);
        tick0(); chk("s7_idle", busy, 1'b0);
`else
        tick0(); chk("s7_check", busy, 1'b1);
`endif
        chk("s7_book", {best_bid, best_ask}, 16'h00FF);
        tick0(); tick0();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                tick($urandom_range(0, 2) == 0, rand_price(), $urandom_range(0, 2) == 0, rand_price());
            end
        end
        for (int i = 0; i < 10; i++) tick0();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/match_sequencer.md
Name: match_sequencer

Overview:
- Controller for the matching datapath. Arbitrates buy and sell order requesters round-robin into a single best-bid/best-ask book stage.
- Sequences the compare, match and cooldown phases, and drives match_signal and enable_count to the downstream spread calculator and statistics/VGA counters.
- Uses the price sentinels shared by the whole design: empty bid = 0, empty ask = all-ones.

Parameters:
- PRICE_W, 8, price width in bits; the ask sentinel is all-ones at this width.
- CNT_W, 16, width of the match counter.
- HOLD_CYCLES, 2, cooldown cycles after each match before new requests are sampled (legal range 1 to 255).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high
- buy_req  input  1  buy order request; held until buy_ack
- buy_price  input  PRICE_W  buy order price; stable while buy_req is high
- sell_req  input  1  sell order request; held until sell_ack
- sell_price  input  PRICE_W  sell order price; stable while sell_req is high
- buy_ack  output  1  one-cycle grant/accept pulse to the buy requester
- sell_ack  output  1  one-cycle grant/accept pulse to the sell requester
- best_bid  output  PRICE_W  registered best bid; 0 = empty
- best_ask  output  PRICE_W  registered best ask; all-ones = empty
- match_signal  output  1  one-cycle pulse when a cross executes
- match_price  output  PRICE_W  execution price, updated with match_signal
- enable_count  output  1  high while both book sides are valid
- match_count  output  CNT_W  saturating count of executed matches
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset values (asynchronous): state = IDLE, best_bid = 0, best_ask = all-ones, match_price = 0, match_count = 0. All acks, match_signal and busy = 0. last_grant = SELL, so the first tie is granted to buy.
- FSM states: IDLE, GRANT, CHECK, MATCH, HOLD. All outputs are registered except enable_count and busy, which decode state/book registers.
- IDLE:
  - Only one requester active: grant it.
  - Both active: grant the side opposite last_grant.
  - Neither active: stay in IDLE.
  - On a grant, record the grantee and update last_grant, then go to GRANT.
- GRANT (1 cycle):
  - Assert the grantee's ack.
  - Buy grantee: best_bid <= max(best_bid, buy_price).
  - Sell grantee: best_ask <= min(best_ask, sell_price).
  - Prices are sampled on the IDLE->GRANT edge, so the price must be stable from req assertion.
  - Next state is CHECK.
- Requester protocol: deassert req the cycle after ack. The FSM is in CHECK then, so the next IDLE never sees a stale request. Requests are ignored outside IDLE.
- CHECK (1 cycle):
  - Go to MATCH if best_bid != 0, best_ask != all-ones and best_bid >= best_ask (unsigned).
  - Otherwise go to IDLE.
- MATCH (1 cycle):
  - match_signal = 1 and match_price <= best_ask (the resting ask sets the price).
  - match_count increments and saturates at all-ones.
  - Clear best_bid to 0 and best_ask to all-ones.
  - Next state is HOLD.
- HOLD: stay for exactly HOLD_CYCLES cycles using an internal down-counter, then go to IDLE.
- Latency: request seen in IDLE -> ack 1 cycle later -> match_signal 3 cycles after the IDLE sample edge.
- enable_count = (best_bid != 0) && (best_ask != all-ones). It falls the cycle after MATCH.
- Equal prices (bid == ask) count as a cross.
- An incoming price worse than the current best leaves the book unchanged, but the request is still acked.
- Reset asserted mid-operation (any state) returns to the reset values immediately. A pending ack is dropped.

Optional Feature:
- Macro: MSEQ_SENTINEL_REJECT_EN.
- Defined:
  - A buy at price 0 or a sell at all-ones is still acked in GRANT, but the book is not updated.
  - reject_pulse (extra output, 1 bit) pulses in that GRANT cycle.
  - The FSM then goes directly to IDLE, skipping CHECK.
- Undefined:
  - No reject_pulse port.
  - Sentinel prices update the book normally and are harmless: max with 0 and min with all-ones leave the book unchanged.
  - The FSM goes through CHECK as usual.

Test Plan:
- Reset, then buy_req with price 0x40 alone -> buy_ack 1 cycle later, best_bid = 0x40, best_ask = 0xFF, no match, enable_count = 0, busy returns low.
- Book bid 0x40, then sell_req at 0x3C -> sell_ack, then CHECK, then match_signal for 1 cycle with match_price = 0x3C and match_count = 1. Book then clears to 0/0xFF, busy stays high 2 HOLD cycles, then IDLE.
- buy_req (0x10) and sell_req (0x20) in the same cycle after reset -> buy granted first, sell granted on the next IDLE, no match (bid < ask), enable_count = 1.
- Sequential sells at 0x50 then 0x60 -> best_ask stays 0x50. Sequential buys at 0x30 then 0x20 -> best_bid stays 0x30.
- Bid 0x50 resting, then sell at 0x50 -> match at 0x50 (equality crosses). Force match_count to all-ones, then another match -> stays all-ones.
- Assert reset during HOLD or GRANT -> all outputs return to reset values on the same edge. With MSEQ_SENTINEL_REJECT_EN, sell at 0xFF -> sell_ack plus reject_pulse, book unchanged.
